// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer: steps FETCH/DECODE/EXECUTE/MEM/WB, handles memory
// handshakes with a wait timeout, traps on illegal opcodes, and counts retired instructions.
module multicycle_sequencer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [6:0]  Op_i,
    input  logic        MemReady_i,
    output logic        MemRead_o,
    output logic        MemWrite_o,
    output logic        MemAddrSel_o,
    output logic        IRWrite_o,
    output logic        RegWrite_o,
    output logic        PCWrite_o,
    output logic [2:0]  State_o,
    output logic        Trap_o,
    output logic [1:0]  TrapCause_o,
    output logic [31:0] Retired_o
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_TRAP    = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CL_NONE   = 3'd0,
        CL_LOAD   = 3'd1,
        CL_STORE  = 3'd2,
        CL_BRANCH = 3'd3,
        CL_REG    = 3'd4
    } op_class_t;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
    localparam logic [7:0] TIMEOUT_CNT   = 8'(TIMEOUT);

    // CL_NONE doubles as the "illegal opcode" marker
    function automatic op_class_t op_class(input logic [6:0] op);
        op_class_t cls;
        case (op)
            7'd3:                          cls = CL_LOAD;
            7'd35:                         cls = CL_STORE;
            7'd99:                         cls = CL_BRANCH;
            7'd19, 7'd51, 7'd55, 7'd103,
            7'd111:                        cls = CL_REG;
            default:                       cls = CL_NONE;
        endcase
        return cls;
    endfunction

    state_t    state_q, state_d;
    op_class_t cls_q, cls_d;
    logic [7:0]  wait_q, wait_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] retired_q, retired_d;

    logic mem_read, mem_write, addr_sel, ir_write, reg_write, pc_write;

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        wait_d    = 8'd0;
        cause_d   = cause_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr_sel  = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        pc_write  = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                if (MemReady_i) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (wait_q == TIMEOUT_CNT) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                cls_d = op_class(Op_i);
                if (cls_d == CL_NONE) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                case (cls_q)
                    CL_LOAD, CL_STORE: state_d = S_MEM;
                    CL_BRANCH: begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end
                    default:           state_d = S_WB;
                endcase
            end
            S_MEM: begin
                addr_sel  = 1'b1;
                mem_read  = (cls_q == CL_LOAD);
                mem_write = (cls_q == CL_STORE);
                if (MemReady_i) begin
                    if (cls_q == CL_STORE) begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == TIMEOUT_CNT) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                state_d   = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_TRAP;
                cause_d = CAUSE_ILLEGAL;
            end
        endcase

        // Reset aborts any in-flight handshake, so nothing may retire in that cycle
        if (rst_i) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            pc_write  = 1'b0;
        end

        retired_d = retired_q + {31'd0, pc_write};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_FETCH;
            cls_q     <= CL_NONE;
            wait_q    <= 8'd0;
            cause_q   <= 2'd0;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            wait_q    <= wait_d;
            cause_q   <= cause_d;
            retired_q <= retired_d;
        end
    end

    assign MemRead_o    = mem_read;
    assign MemWrite_o   = mem_write;
    assign MemAddrSel_o = addr_sel;
    assign IRWrite_o    = ir_write;
    assign RegWrite_o   = reg_write;
    assign PCWrite_o    = pc_write;
    assign State_o      = state_q;
    assign Trap_o       = (state_q == S_TRAP);
    assign TrapCause_o  = cause_q;
    assign Retired_o    = retired_q;

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 SHALL provide parameter: TIMEOUT, 15, max wait cycles for MemReady_i before a memory-timeout trap (range 1..255).
REQ-002 SHALL provide ports, one per line:
- clk_i  input  1  single clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- Op_i  input  7  opcode field of the instruction register (Instr[6:0]).
- MemReady_i  input  1  memory acknowledge for the current MemRead_o/MemWrite_o request.
- MemRead_o  output  1  memory read request (instruction fetch or load).
- MemWrite_o  output  1  memory write request (store).
- MemAddrSel_o  output  1  memory address source: 0 = PC, 1 = ALU result.
- IRWrite_o  output  1  instruction register load strobe.
- RegWrite_o  output  1  register file write strobe.
- PCWrite_o  output  1  PC update strobe; exactly one pulse per retired instruction.
- State_o  output  3  current state encoding.
- Trap_o  output  1  sequencer halted in TRAP.
- TrapCause_o  output  2  0 = none, 1 = illegal opcode, 2 = memory timeout.
- Retired_o  output  32  count of retired instructions.

Function
REQ-003 SHALL implement states FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=5; codes 6 and 7 SHALL transition to TRAP with cause 1.
REQ-004 SHALL make all strobe outputs Moore, decoded from state plus the registered opcode class, except IRWrite_o and PCWrite_o, which also depend on MemReady_i as stated below.
REQ-005 FETCH: MemRead_o=1, MemAddrSel_o=0; on MemReady_i=1, IRWrite_o=1 in that cycle and next state is DECODE; otherwise stay.
REQ-006 DECODE (1 cycle): latch the opcode class from Op_i into a register.
- Legal opcodes are 3, 19, 35, 51, 55, 99, 103, 111.
- Legal opcode: next state EXECUTE.
- Any other opcode: next state TRAP, TrapCause_o=1.
REQ-007 EXECUTE (1 cycle), next state by opcode class:
- 3 or 35: MEM.
- 99: FETCH, with PCWrite_o=1.
- 19, 51, 55, 103, 111: WB.
REQ-008 MEM:
- Outputs: MemAddrSel_o=1; MemRead_o=1 for opcode 3, MemWrite_o=1 for opcode 35; request held stable until MemReady_i=1.
- On MemReady_i=1, opcode 3: next state WB.
- On MemReady_i=1, opcode 35: next state FETCH, with PCWrite_o=1 in that cycle.
REQ-009 WB (1 cycle): RegWrite_o=1, PCWrite_o=1; next state FETCH.
REQ-010 SHALL keep an 8-bit wait counter.
- Clears on entry to FETCH or MEM.
- Increments each cycle in FETCH/MEM with MemReady_i=0.
- When the count equals TIMEOUT with MemReady_i still 0, next state TRAP, TrapCause_o=2.
- MemReady_i=1 on the same cycle the count reaches TIMEOUT SHALL win; no trap.
REQ-011 TRAP:
- Trap_o=1; all strobes 0.
- TrapCause_o held at the recorded cause.
- Exits only on rst_i.
REQ-012 MemReady_i SHALL be ignored in DECODE, EXECUTE, WB and TRAP.
REQ-013 Retired_o SHALL increment by 1 on every cycle with PCWrite_o=1, wrapping 0xFFFFFFFF to 0.
REQ-014 Latency: cycles per instruction, where N = number of memory wait cycles:
- branch: 3+N
- ALU/lui/jal/jalr: 4+N
- store: 4+N
- load: 5+N
REQ-015 MemRead_o and MemWrite_o SHALL never be 1 in the same cycle.

Reset
REQ-016 With rst_i=1 at a rising edge, the next state SHALL be:
- state FETCH; wait counter 0; Retired_o 0; TrapCause_o 0; Trap_o 0; opcode class register 0.
REQ-017 While rst_i=1, all strobes (MemRead_o, MemWrite_o, IRWrite_o, RegWrite_o, PCWrite_o) SHALL be forced to 0.
REQ-018 Reset asserted mid-instruction, including in MEM with a request outstanding, SHALL abort the instruction without incrementing Retired_o.

Verification
REQ-019 Reset, then Op_i=51 with MemReady_i=1 constant -> states 0,1,2,4,0; RegWrite_o and PCWrite_o pulse in the WB cycle; Retired_o=1 after 4 cycles.
REQ-020 Op_i=3 with MemReady_i low for 2 cycles in MEM -> MemRead_o=1 and MemAddrSel_o=1 held 3 cycles, then WB; 7 cycles total; Retired_o increments once.
REQ-021 Op_i=35, MemReady_i=1 -> MemWrite_o=1 for 1 cycle, PCWrite_o in the same cycle, RegWrite_o never 1; Retired_o increments once.
REQ-022 Op_i=0x7F in DECODE -> TRAP next cycle, Trap_o=1, TrapCause_o=1, all strobes 0 for 20 cycles; rst_i pulse returns state to FETCH.
REQ-023 MemReady_i=0 in FETCH with TIMEOUT=15 -> TRAP with cause 2 after 16 FETCH cycles; repeat with MemReady_i=1 on the 16th FETCH cycle -> DECODE, no trap.
REQ-024 Preload Retired_o=0xFFFFFFFF by force, retire one branch (Op_i=99) -> Retired_o=0; rst_i asserted during MEM -> Retired_o unchanged, state FETCH.
